// File: rtl/sysref_pkg.sv
// Shared types for the SYSREF qualifier and its capture front end.
package sysref_pkg;

  // Lock tracker states.
  typedef enum logic [1:0] {
    SEARCH,
    ACQUIRE,
    LOCKED
  } sysref_state_t;

  // Forwarding modes selected by mode_i.
  typedef enum logic [1:0] {
    MODE_PASS,
    MODE_CONT,
    MODE_ONESHOT,
    MODE_OFF
  } sysref_mode_t;

endpackage

// File: rtl/sysref_capture.sv
// SYSREF-class pin front end: IOB capture flop, one retime stage and a
// rising-edge detect on the retimed copy. Reusable on any SYSREF-like pin.
module sysref_capture (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic sysref_i,
  output logic stg_o,
  output logic rise_o
);

  // The first flop must be packed into the pad so the sample point is fixed.
  (* IOB = "TRUE" *) logic r_cap;
  logic r_stg;
  logic r_prev;

  // Capture, retime and keep the previous retimed value for edge detection.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cap  <= 1'b0;
      r_stg  <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_cap  <= sysref_i;
      r_stg  <= r_cap;
      r_prev <= r_stg;
    end
  end

  assign stg_o  = r_stg;
  assign rise_o = r_stg & ~r_prev;

endmodule

// File: rtl/sysref_qualifier.sv
// SYSREF qualifier: measures the interval between SYSREF rising edges,
// tracks lock against PERIOD and forwards a fixed 3-cycle-latency PL_SYSREF
// in passthrough, lock-gated continuous or armed one-shot mode.
module sysref_qualifier
  import sysref_pkg::*;
#(
  parameter int PERIOD     = 16,
  parameter int CNT_WIDTH  = 8,
  parameter int LOCK_COUNT = 4,
  parameter int ERR_WIDTH  = 8
) (
  input  logic                 sysclk_i,
  input  logic                 rst_n_i,
  input  logic                 sysref_i,
  input  logic [1:0]           mode_i,
  input  logic                 arm_i,
  input  logic                 err_clr_i,
  output logic                 pl_sysref_o,
  output logic                 locked_o,
  output logic                 oneshot_done_o,
  output logic [ERR_WIDTH-1:0] err_count_o
);

  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_GOOD = CNT_WIDTH'(PERIOD - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MISS = CNT_WIDTH'(PERIOD);
  localparam logic [ERR_WIDTH-1:0] ERR_MAX  = '1;
  localparam logic [GW-1:0]        GCNT_LAST = GW'(LOCK_COUNT - 1);
  localparam logic [GW-1:0]        GCNT_FULL = GW'(LOCK_COUNT);

  logic                 w_stg;
  logic                 w_rise;
  logic                 w_good;
  logic                 w_bad;
  logic                 w_miss;
  sysref_mode_t         w_mode;
  sysref_state_t        w_state_nxt;
  logic [GW-1:0]        w_gcnt_nxt;
  logic                 w_err_inc;
  logic                 w_gate_dec;
  logic                 w_gate;
  logic                 w_fire;

  logic [CNT_WIDTH-1:0] r_cnt;
  sysref_state_t        r_state;
  logic [GW-1:0]        r_gcnt;
  logic [ERR_WIDTH-1:0] r_err;
  logic                 r_locked;
  logic                 r_gate_hold;
  logic                 r_pl;
  logic                 r_armed;
  logic                 r_done;

  sysref_capture u_capture (
    .clk_i    (sysclk_i),
    .rst_n_i  (rst_n_i),
    .sysref_i (sysref_i),
    .stg_o    (w_stg),
    .rise_o   (w_rise)
  );

  assign w_mode = sysref_mode_t'(mode_i);

  // Interval classification against the count reached just before the edge.
  assign w_good = w_rise & (r_cnt == CNT_GOOD);
  assign w_bad  = w_rise & ~w_good;
  assign w_miss = ~w_rise & (r_cnt == CNT_MISS);

  // Interval counter: restarts on each edge, saturates so long gaps stay "missing".
  always_ff @(posedge sysclk_i or negedge rst_n_i) begin
    if (!rst_n_i)            r_cnt <= '0;
    else if (w_rise)         r_cnt <= '0;
    else if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
  end

  // Lock tracker next-state; the first edge in SEARCH is only a reference.
  always_comb begin
    w_state_nxt = r_state;
    w_gcnt_nxt  = r_gcnt;
    w_err_inc   = 1'b0;
    case (r_state)
      SEARCH: begin
        if (w_rise) begin
          w_state_nxt = ACQUIRE;
          w_gcnt_nxt  = '0;
        end
      end
      ACQUIRE: begin
        if (w_good) begin
          if (r_gcnt == GCNT_LAST) begin
            w_state_nxt = LOCKED;
            w_gcnt_nxt  = GCNT_FULL;
          end else begin
            w_gcnt_nxt  = r_gcnt + 1'b1;
          end
        end else if (w_bad) begin
          w_gcnt_nxt  = '0;
        end else if (w_miss) begin
          w_state_nxt = SEARCH;
          w_gcnt_nxt  = '0;
        end
      end
      LOCKED: begin
        if (w_bad) begin
          w_state_nxt = ACQUIRE;
          w_gcnt_nxt  = '0;
          w_err_inc   = 1'b1;
        end else if (w_miss) begin
          w_state_nxt = SEARCH;
          w_gcnt_nxt  = '0;
          w_err_inc   = 1'b1;
        end
      end
      default: begin
        w_state_nxt = SEARCH;
        w_gcnt_nxt  = '0;
      end
    endcase
  end

  // Lock tracker state, good-interval count and registered lock flag.
  always_ff @(posedge sysclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state  <= SEARCH;
      r_gcnt   <= '0;
      r_locked <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_gcnt   <= w_gcnt_nxt;
      r_locked <= (w_state_nxt == LOCKED);
    end
  end

  // Saturating error counter; a clear wins over a same-cycle increment.
  always_ff @(posedge sysclk_i or negedge rst_n_i) begin
    if (!rst_n_i)                        r_err <= '0;
    else if (err_clr_i)                  r_err <= '0;
    else if (w_err_inc && r_err != ERR_MAX) r_err <= r_err + 1'b1;
  end

  // Gate decision, taken only in the rise cycle from the pre-edge state.
  always_comb begin
    w_gate_dec = 1'b0;
    case (w_mode)
      MODE_PASS:    w_gate_dec = 1'b1;
      MODE_CONT:    w_gate_dec = (r_state == LOCKED) & w_good;
      MODE_ONESHOT: w_gate_dec = r_armed & (r_state == LOCKED) & w_good;
      MODE_OFF:     w_gate_dec = 1'b0;
      default:      w_gate_dec = 1'b0;
    endcase
  end

  // Hold the decision for the whole high time so a mode change cannot chop a pulse.
  assign w_gate = w_rise ? w_gate_dec : r_gate_hold;
  assign w_fire = w_rise & w_gate_dec & (w_mode == MODE_ONESHOT);

  // Output stage: one flop after the retime stage gives 3 cycles pin-to-output.
  always_ff @(posedge sysclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_gate_hold <= 1'b0;
      r_pl        <= 1'b0;
    end else begin
      r_gate_hold <= w_gate;
      r_pl        <= w_stg & w_gate;
    end
  end

  // One-shot arming. An arm landing on a firing edge re-arms for the next edge,
  // so it wins over the fire's clear/set.
  always_ff @(posedge sysclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_armed <= 1'b0;
      r_done  <= 1'b0;
    end else if (w_mode != MODE_ONESHOT) begin
      r_armed <= 1'b0;
    end else if (arm_i) begin
      r_armed <= 1'b1;
      r_done  <= 1'b0;
    end else if (w_fire) begin
      r_armed <= 1'b0;
      r_done  <= 1'b1;
    end
  end

  assign pl_sysref_o    = r_pl;
  assign locked_o       = r_locked;
  assign oneshot_done_o = r_done;
  assign err_count_o    = r_err;

endmodule

// File: doc/sysref_qualifier.md
Name: sysref_qualifier

Overview:
- Parametrised successor to the plain PL_SYSREF capture flop.
- Captures the SYSREF input in an IOB register, then qualifies its period against an expected value and tracks lock.
- Forwards a fixed-latency PL_SYSREF to the RFDC in one of three modes: passthrough, lock-gated continuous, or armed one-shot.
- Sits between the board SYSREF pin and the RFDC PL_SYSREF input, in the SYSCLK domain.

Parameters:
PERIOD, 16, expected interval between SYSREF rising edges, in sysclk cycles (must be >= 2)
CNT_WIDTH, 8, width of the interval counter (2^CNT_WIDTH-1 must be >= PERIOD)
LOCK_COUNT, 4, consecutive good intervals needed to enter LOCKED
ERR_WIDTH, 8, width of the saturating error counter

Ports:
sysclk_i  in  1  SYSCLK; the only clock
rst_n_i  in  1  asynchronous, active-low reset
sysref_i  in  1  raw SYSREF from the pin
mode_i  in  2  0=passthrough, 1=continuous gated, 2=one-shot, 3=off
arm_i  in  1  one-cycle pulse; arms the one-shot (honoured only when mode_i==2)
err_clr_i  in  1  clears err_count_o
pl_sysref_o  out  1  qualified SYSREF to RFDC
locked_o  out  1  high in LOCKED state
oneshot_done_o  out  1  sticky; set when the one-shot fires, cleared by arm_i
err_count_o  out  ERR_WIDTH  saturating count of period errors while LOCKED

Behaviour:
- Reset (asynchronous, rst_n_i low): every register returns to 0 and the FSM returns to SEARCH. Outputs are all 0 immediately, with no clock needed.
- Pipeline:
  - cap_q <= sysref_i, using an IOB register.
  - stg_q <= cap_q.
  - rise = stg_q & ~prev_q, where prev_q is the previous stg_q.
  - pl_sysref_o <= stg_q & gate.
  - Latency from sysref_i to pl_sysref_o is exactly 3 cycles in every mode.
- Interval counter cnt:
  - Cleared to 0 in the rise cycle; otherwise incremented, saturating at 2^CNT_WIDTH-1.
  - good = rise & (cnt == PERIOD-1).
  - bad = rise & ~good.
  - missing = ~rise & (cnt == PERIOD), i.e. PERIOD+1 cycles with no edge.
- FSM (states SEARCH, ACQUIRE, LOCKED; good_cnt counts 0..LOCK_COUNT):
  - SEARCH: on rise go to ACQUIRE with good_cnt=0. The first edge is only the reference point.
  - ACQUIRE: on good, increment good_cnt; when good_cnt reaches LOCK_COUNT, go to LOCKED. On bad, set good_cnt=0 and stay. On missing, go to SEARCH.
  - LOCKED: on good, stay. On bad, go to ACQUIRE with good_cnt=0 and increment err_count. On missing, go to SEARCH and increment err_count.
  - locked_o is registered: (state==LOCKED).
- err_count:
  - Saturates at all ones.
  - err_clr_i takes priority over an increment in the same cycle; the result is 0.
- Gate:
  - Decided in the rise cycle and held while stg_q stays high. When stg_q is low, the gate is don't-care.
  - The decision uses the FSM state before that edge updates it.
  - Mode 0: open.
  - Mode 3: closed.
  - Mode 1: open iff state==LOCKED & good. The edge that completes lock is not forwarded, and neither is a bad edge.
  - Mode 2: open iff armed & state==LOCKED & good. When it opens, armed clears and oneshot_done sets in the same cycle.
- arm_i:
  - When mode_i==2, sets armed and clears oneshot_done.
  - If arm_i coincides with a rise, it takes effect from the next edge.
  - Leaving mode 2 clears armed.
- A mode_i change while a pulse is being forwarded does not truncate that pulse. The FSM and counters run in every mode.
- A SYSREF high-time of PERIOD or more is legal; only rising edges matter.

Decomposition:
- sysref_pkg holds:
  - typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} sysref_state_t;
  - typedef enum logic [1:0] {MODE_PASS, MODE_CONT, MODE_ONESHOT, MODE_OFF} sysref_mode_t.
- One sub-module, sysref_capture, holds the IOB flop, the retime stage and the rise detect, so it can be reused on other SYSREF-class pins. The FSM, gate and counters stay in the top.

Test Plan:
All scenarios use PERIOD=16, LOCK_COUNT=4, SYSREF pulses 2 cycles wide.
1. Mode 0, single pulse on sysref_i at cycles 10-11 -> pl_sysref_o high at cycles 13-14; locked_o stays 0.
2. Mode 1, periodic edges every 16 cycles starting at cycle 10 -> edges 1-5 are not forwarded; locked_o rises after edge 5; edge 6 (cycle 90) appears on pl_sysref_o at cycles 93-94, and every edge after it is forwarded.
3. Locked, mode 1, one interval of 15 cycles -> that edge is blocked, err_count_o=1 and locked_o falls. Four good intervals later locked_o is high again, and the edge after relock is forwarded.
4. Locked, sysref_i held low -> 17 cycles after the last rise is detected, the FSM is in SEARCH with err_count_o=1. Then err_clr_i coincident with a second missing event -> err_count_o=0.
5. Mode 2, locked, arm_i pulse -> exactly one subsequent edge is forwarded and oneshot_done_o=1; later edges are blocked. A re-arm clears oneshot_done_o and forwards one more edge.
6. Mode 0, rst_n_i asserted mid-pulse -> pl_sysref_o and locked_o are 0 asynchronously. After release, a new edge sequence must re-lock from SEARCH.
